alu_seq: RTL and testbench

//  Parametrised, registered successor to the 4-bit combinational ALU.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation handshake in, result/flags handshake out.
// The master side drives requests and consumes results; the slave side is the ALU.
interface alu_seq_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             zero;
   logic             carry;
   logic             eq;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, res, zero, carry, eq
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, res, zero, carry, eq
   );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: one op in flight, single-cycle logic/arith,
// bit-serial shifts and shift-add multiply, result plus flags held until consumed.
module alu_seq #(
   parameter  int WIDTH = 4,
   localparam int SHW   = $clog2(WIDTH),
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input logic       clk,
   input logic       rst,
   alu_seq_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_XNOR = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;

   state_t           state, nxt;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    cnt, cnt_init, s_amt;
   logic             shift_en;
   logic             accept, last;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] acc_step, res_n;
   logic             carry_n;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);

   // Shift amount folded into 0..WIDTH-1 so non-power-of-two widths stay in range.
   assign s_amt = CW'(int'(bus.b[SHW-1:0]) % WIDTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt    = state;
      accept = 1'b0;
      last   = 1'b0;
      case (state)
         IDLE: if (bus.in_valid) begin
            accept = 1'b1;
            nxt    = EXEC;
         end
         EXEC: if (cnt == CW'(1)) begin
            last = 1'b1;
            nxt  = DONE;
         end
         DONE: if (bus.out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_init = CW'(1);
      case (bus.op)
         OP_SHL, OP_SHR: cnt_init = (s_amt == '0) ? CW'(1) : s_amt;
         OP_MUL:         cnt_init = CW'(WIDTH);
         default:        cnt_init = CW'(1);
      endcase
   end

   always_comb begin
      sum      = {1'b0, a_r} + {1'b0, b_r};
      diff     = {1'b0, a_r} - {1'b0, b_r};
      acc_step = acc;
      case (op_r)
         OP_SHL: if (shift_en) acc_step = acc << 1;
         OP_SHR: if (shift_en) acc_step = acc >> 1;
         OP_MUL: if (mplier[0]) acc_step = acc + mcand;
         default: acc_step = acc;
      endcase
      res_n   = '0;
      carry_n = 1'b0;
      case (op_r)
         OP_ADD: begin res_n = sum[WIDTH-1:0];  carry_n = sum[WIDTH];   end
         OP_SUB: begin res_n = diff[WIDTH-1:0]; carry_n = ~diff[WIDTH]; end
         OP_NAND: res_n = ~(a_r & b_r);
         OP_XNOR: res_n = ~(a_r ^ b_r);
         OP_SHL, OP_SHR, OP_MUL: res_n = acc_step;
         default: res_n = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         shift_en  <= 1'b0;
         bus.res   <= '0;
         bus.zero  <= 1'b0;
         bus.carry <= 1'b0;
         bus.eq    <= 1'b0;
      end else if (accept) begin
         op_r     <= bus.op;
         a_r      <= bus.a;
         b_r      <= bus.b;
         acc      <= (bus.op == OP_MUL) ? '0 : bus.a;
         mcand    <= bus.a;
         mplier   <= bus.b;
         cnt      <= cnt_init;
         shift_en <= (s_amt != '0);
      end else if (state == EXEC) begin
         acc    <= acc_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         // Result and flags share the final EXEC edge so they appear with out_valid.
         if (last) begin
            bus.res   <= res_n;
            bus.zero  <= (res_n == '0);
            bus.carry <= carry_n;
            bus.eq    <= (a_r == b_r);
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single ops, hand sequences for
// back-pressure, mid-operation reset and an 8-bit multiply.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total    = 0;

   alu_seq_if #(.WIDTH(4)) bus ();
   alu_seq_if #(.WIDTH(8)) bus8 ();

   alu_seq #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
   alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      logic       zero;
      logic       carry;
      logic       eq;
      int         lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Present an op while IDLE, then count edges until out_valid (bounded).
   task automatic do_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        output int lat);
      bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.out_valid) break;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_after_handshake", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      logic [3:0] held;

      vecs[0]  = '{3'b000, 4'h9, 4'h8, 4'h1, 1'b0, 1'b1, 1'b0, 1};
      vecs[1]  = '{3'b001, 4'h5, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1};
      vecs[2]  = '{3'b001, 4'h3, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 1};
      vecs[3]  = '{3'b010, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1};
      vecs[4]  = '{3'b011, 4'h5, 4'h6, 4'hC, 1'b0, 1'b0, 1'b0, 1};
      vecs[5]  = '{3'b100, 4'h3, 4'h2, 4'hC, 1'b0, 1'b0, 1'b0, 2};
      vecs[6]  = '{3'b101, 4'h8, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{3'b100, 4'h1, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0, 3};
      vecs[8]  = '{3'b101, 4'hC, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{3'b110, 4'h7, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 4};
      vecs[10] = '{3'b110, 4'h0, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0, 4};
      vecs[11] = '{3'b111, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 1};
      vecs[12] = '{3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1};

      bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
      bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_res",       {28'd0, bus.res},       32'd0);
      chk("rst_flags",     {29'd0, bus.zero, bus.carry, bus.eq}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_lat", i),   lat,                       vecs[i].lat);
         chk($sformatf("v%0d_res", i),   {28'd0, bus.res},          {28'd0, vecs[i].res});
         chk($sformatf("v%0d_zero", i),  {31'd0, bus.zero},         {31'd0, vecs[i].zero});
         chk($sformatf("v%0d_carry", i), {31'd0, bus.carry},        {31'd0, vecs[i].carry});
         chk($sformatf("v%0d_eq", i),    {31'd0, bus.eq},           {31'd0, vecs[i].eq});
         consume();
      end

      // Back-pressure: ADD 2+3 held for 5 cycles, a pending request must be ignored.
      do_op(3'b000, 4'h2, 4'h3, lat);
      chk("bp_lat", lat, 1);
      held = bus.res;
      chk("bp_res", {28'd0, held}, 32'd5);
      bus.op = 3'b000; bus.a = 4'h1; bus.b = 4'h2; bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
         chk("bp_hold",      {28'd0, bus.res, bus.zero, bus.carry, bus.eq} >> 3,
                             {28'd0, 4'h5});
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_idle",      {31'd0, bus.in_ready},  32'd1);
      chk("bp_idle_res",  {28'd0, bus.res},       32'd5);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("b2b_accepted", {31'd0, bus.in_ready},  32'd0);
      @(posedge clk); #1;
      chk("b2b_valid",    {31'd0, bus.out_valid}, 32'd1);
      chk("b2b_res",      {28'd0, bus.res},       32'd3);
      consume();

      // Reset in the middle of a multiply, with flags previously set.
      do_op(3'b001, 4'h5, 4'h5, lat);
      consume();
      bus.op = 3'b110; bus.a = 4'h7; bus.b = 4'h3; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mrst_res",       {28'd0, bus.res},       32'd0);
      chk("mrst_flags",     {29'd0, bus.zero, bus.carry, bus.eq}, 32'd0);
      chk("mrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      bus.op = 3'b000; bus.a = 4'h1; bus.b = 4'h1; bus.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mrst_no_accept", {31'd0, bus.in_ready},  32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("post_rst_accept", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("post_rst_res",   {28'd0, bus.res},       32'd2);
      consume();

      // WIDTH=8 multiply: FF*FF low byte is 01 after 8 EXEC cycles.
      bus8.op = 3'b110; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         lat++;
         if (bus8.out_valid) break;
      end
      chk("w8_mul_lat", lat, 8);
      chk("w8_mul_res", {24'd0, bus8.res}, 32'h01);
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      chk("w8_idle", {31'd0, bus8.in_ready}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
